// File: rtl/lif_neuron_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lif_neuron_param
// Description : Parametrised leaky integrate-and-fire neuron. Each enabled
//               step applies a shift-based leak, adds the input current with
//               saturation, compares against a runtime threshold and, on a
//               spike, resets the membrane (zero or subtractive), enters a
//               refractory period and bumps a saturating spike counter.
//
// Ports       : clk          clock
//               rst_n        asynchronous active-low reset
//               en           step enable (one integration step per cycle)
//               current      unsigned input current for this step
//               thresh       unsigned firing threshold (0 disables firing)
//               clr_count    synchronous clear of spike_count
//               state        membrane potential (registered)
//               spike        one-cycle spike pulse (registered)
//               refractory   high while the refractory counter is non-zero
//               spike_count  saturating count of spikes since reset/clear
//
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_param #(
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int RESET_MODE = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] thresh,
    input  logic             clr_count,
    output logic [WIDTH-1:0] state,
    output logic             spike,
    output logic             refractory,
    output logic [CNT_W-1:0] spike_count
);

    localparam logic [7:0]       c_refrac    = 8'(REFRAC);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] c_state_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_state;
    logic             r_spike;
    logic [7:0]       r_rcnt;
    logic             r_refractory;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next;
    logic             w_integrate;
    logic             w_fire;
    logic [WIDTH-1:0] w_state_nxt;
    logic [7:0]       w_rcnt_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    // One extra bit of headroom: state - leak never underflows, so only the
    // addition of current can overflow, and the carry bit flags saturation.
    assign w_leak = r_state >> LEAK_SHIFT;
    assign w_sum  = {1'b0, r_state} - {1'b0, w_leak} + {1'b0, current};
    assign w_next = w_sum[WIDTH] ? c_state_max : w_sum[WIDTH-1:0];

    assign w_integrate = en && (r_rcnt == 8'd0);
    assign w_fire      = w_integrate && (thresh != '0) && (w_next >= thresh);

    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        if (en) begin
            if (r_rcnt != 8'd0) begin
                w_rcnt_nxt = r_rcnt - 8'd1;
            end else if (w_fire) begin
                w_rcnt_nxt  = c_refrac;
                // next >= thresh on a fire, so the subtraction is safe.
                w_state_nxt = (RESET_MODE != 0) ? (w_next - thresh) : '0;
            end else begin
                w_state_nxt = w_next;
            end
        end
    end

    // A clear in the same cycle as a fire leaves exactly that one spike counted.
    always_comb begin
        w_count_nxt = r_count;
        if (clr_count) begin
            w_count_nxt = w_fire ? CNT_W'(1) : '0;
        end else if (w_fire && (r_count != c_cnt_max)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= '0;
            r_spike      <= 1'b0;
            r_rcnt       <= 8'd0;
            r_refractory <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_spike      <= w_fire;
            r_rcnt       <= w_rcnt_nxt;
            r_refractory <= (w_rcnt_nxt != 8'd0);
            r_count      <= w_count_nxt;
        end
    end

    assign state       = r_state;
    assign spike       = r_spike;
    assign refractory  = r_refractory;
    assign spike_count = r_count;

endmodule
`default_nettype wire
